// File: rtl/stream_packer_pkg.sv
// rtl/stream_packer_pkg.sv - shared state encoding, mask constants and 72-bit beat field offsets
package stream_packer_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } state_t;

    localparam logic [1:0] MASK_LO   = 2'b01;
    localparam logic [1:0] MASK_BOTH = 2'b11;

    // Field offsets are functions of the input word width so non-default builds stay consistent.
    function automatic int beat_lo_lsb(input int in_w);
        beat_lo_lsb = 0 * in_w;
    endfunction

    function automatic int beat_hi_lsb(input int in_w);
        beat_hi_lsb = in_w;
    endfunction

    function automatic int beat_mask_lsb(input int in_w);
        beat_mask_lsb = 2 * in_w;
    endfunction

    function automatic int beat_last_bit(input int in_w);
        beat_last_bit = 2 * in_w + 2;
    endfunction

    localparam int BEAT_WORD_W   = 32;
    localparam int BEAT_W        = 2 * BEAT_WORD_W + 8;
    localparam int BEAT_LO_LSB   = 0;
    localparam int BEAT_HI_LSB   = BEAT_WORD_W;
    localparam int BEAT_MASK_LSB = 2 * BEAT_WORD_W;
    localparam int BEAT_LAST_BIT = 2 * BEAT_WORD_W + 2;
    localparam int BEAT_PAD_LSB  = 2 * BEAT_WORD_W + 3;

endpackage

// File: rtl/stream_packer.sv
// rtl/stream_packer.sv - packs pairs of stream words into one beat; STREAM_PACKER_STATS_EN adds pkt_count
module stream_packer
    import stream_packer_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 72,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [IN_W-1:0]  ss_data,
    input  logic             ss_last,
    input  logic             ss_valid,
    output logic             ss_ready,
    output logic [OUT_W-1:0] ms_data,
    output logic             ms_valid,
    input  logic             ms_ready
`ifdef STREAM_PACKER_STATS_EN
    ,
    output logic [CNT_W-1:0] pkt_count
`endif
);

    localparam int LO_LSB   = beat_lo_lsb(IN_W);
    localparam int HI_LSB   = beat_hi_lsb(IN_W);
    localparam int MASK_LSB = beat_mask_lsb(IN_W);
    localparam int LAST_BIT = beat_last_bit(IN_W);

    state_t           r_state;
    logic [IN_W-1:0]  r_hold;
    logic [OUT_W-1:0] r_ms_data;
    logic             r_ms_valid;
    logic [OUT_W-1:0] w_beat;
    logic             w_ss_ready;
    logic             w_ss_fire;
    logic             w_ms_fire;

    // The output register frees up on the same edge it is drained, so a new beat may load without a bubble.
    assign w_ss_ready = resetn && (!r_ms_valid || ms_ready);
    assign w_ss_fire  = ss_valid && w_ss_ready;
    assign w_ms_fire  = r_ms_valid && ms_ready;

    assign ss_ready = w_ss_ready;
    assign ms_data  = r_ms_data;
    assign ms_valid = r_ms_valid;

    always_comb begin
        w_beat = '0;
        if (r_state == ST_HALF) begin
            w_beat[LO_LSB +: IN_W]  = r_hold;
            w_beat[HI_LSB +: IN_W]  = ss_data;
            w_beat[MASK_LSB +: 2]   = MASK_BOTH;
            w_beat[LAST_BIT]        = ss_last;
        end else begin
            w_beat[LO_LSB +: IN_W]  = ss_data;
            w_beat[MASK_LSB +: 2]   = MASK_LO;
            w_beat[LAST_BIT]        = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= ST_EMPTY;
            r_hold     <= '0;
            r_ms_data  <= '0;
            r_ms_valid <= 1'b0;
        end else begin
            if (w_ms_fire) begin
                r_ms_valid <= 1'b0;
            end
            if (w_ss_fire) begin
                case (r_state)
                    ST_EMPTY: begin
                        if (ss_last) begin
                            r_ms_data  <= w_beat;
                            r_ms_valid <= 1'b1;
                        end else begin
                            r_hold  <= ss_data;
                            r_state <= ST_HALF;
                        end
                    end
                    ST_HALF: begin
                        r_ms_data  <= w_beat;
                        r_ms_valid <= 1'b1;
                        r_state    <= ST_EMPTY;
                    end
                    default: r_state <= ST_EMPTY;
                endcase
            end
        end
    end

`ifdef STREAM_PACKER_STATS_EN
    logic [CNT_W-1:0] r_pkt_count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pkt_count <= '0;
        end else if (w_ms_fire && r_ms_data[LAST_BIT]) begin
            r_pkt_count <= r_pkt_count + 1'b1;
        end
    end

    assign pkt_count = r_pkt_count;
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_packer.sv
// tb/tb_stream_packer.sv - directed and randomized checks of stream_packer against a queue-based model
module tb_stream_packer;
    import stream_packer_pkg::*;

    localparam int IN_W  = 32;
    localparam int OUT_W = 72;
`ifdef STREAM_PACKER_STATS_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif

    logic             clk = 1'b0;
    logic             resetn;
    logic [IN_W-1:0]  ss_data;
    logic             ss_last;
    logic             ss_valid;
    logic             ss_ready;
    logic [OUT_W-1:0] ms_data;
    logic             ms_valid;
    logic             ms_ready;
`ifdef STREAM_PACKER_STATS_EN
    logic [CNT_W-1:0] pkt_count;
`endif

    stream_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .ss_data  (ss_data),
        .ss_last  (ss_last),
        .ss_valid (ss_valid),
        .ss_ready (ss_ready),
        .ms_data  (ms_data),
        .ms_valid (ms_valid),
        .ms_ready (ms_ready)
`ifdef STREAM_PACKER_STATS_EN
        ,
        .pkt_count(pkt_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [OUT_W-1:0] exp_q[$];
    logic [IN_W-1:0]  pkt_words[$];
    int               exp_pkts = 0;

    function automatic logic [OUT_W-1:0] beat(input logic [IN_W-1:0] lo, input logic [IN_W-1:0] hi,
                                              input logic [1:0] mask, input logic last);
        logic [OUT_W-1:0] b;
        b = '0;
        b[BEAT_LO_LSB +: IN_W] = lo;
        b[BEAT_HI_LSB +: IN_W] = hi;
        b[BEAT_MASK_LSB +: 2]  = mask;
        b[BEAT_LAST_BIT]       = last;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // A packet is cut into consecutive two-word chunks; a trailing single word forms its own beat.
    task automatic model_word(input logic [IN_W-1:0] w, input logic last, output bit done);
        pkt_words.push_back(w);
        done = 1'b0;
        if (pkt_words.size() == 2) begin
            exp_q.push_back(beat(pkt_words[0], pkt_words[1], 2'b11, last));
            done = 1'b1;
        end else if (last) begin
            exp_q.push_back(beat(pkt_words[0], '0, 2'b01, 1'b1));
            done = 1'b1;
        end
        if (done) pkt_words.delete();
    endtask

    task automatic cycle(output bit acc);
        bit ss_f, ms_f, done, stalled;
        logic [OUT_W-1:0] held, e;
        @(negedge clk);
        chk("ss_ready_rule", ss_ready, resetn && (!ms_valid || ms_ready));
        ss_f = ss_valid && ss_ready && resetn;
        ms_f = ms_valid && ms_ready && resetn;
        done = 1'b0;
        if (ms_f) begin
            chk("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("beat_data", ms_data, e);
                if (e[BEAT_LAST_BIT]) exp_pkts++;
            end
        end
        if (ss_f) model_word(ss_data, ss_last, done);
        stalled = ms_valid && !ms_ready && resetn;
        held    = ms_data;
        acc     = ss_f;
        @(posedge clk);
        #1;
        if (!resetn) begin
            exp_q.delete();
            pkt_words.delete();
            exp_pkts = 0;
            chk("reset_ms_valid", ms_valid, 0);
            chk("reset_ms_data", ms_data, 0);
            chk("reset_ss_ready", ss_ready, 0);
        end else begin
            if (done) chk("latency_valid", ms_valid, 1);
            if (stalled) begin
                chk("stall_valid", ms_valid, 1);
                chk("stall_data", ms_data, held);
            end
        end
`ifdef STREAM_PACKER_STATS_EN
        chk("pkt_count", pkt_count, exp_pkts % (1 << CNT_W));
`endif
    endtask

    task automatic send(input logic [IN_W-1:0] w, input logic l);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        ss_data  = w;
        ss_last  = l;
        ss_valid = 1'b1;
        while (!acc && n < 64) begin
            cycle(acc);
            n++;
        end
        if (!acc) chk("send_timeout", acc, 1);
        ss_valid = 1'b0;
    endtask

    initial begin
        bit acc;
        resetn   = 1'b0;
        ss_data  = '0;
        ss_last  = 1'b0;
        ss_valid = 1'b0;
        ms_ready = 1'b1;
        cycle(acc);
        cycle(acc);
        resetn = 1'b1;
        cycle(acc);

        send(32'hA, 1'b0);
        send(32'hB, 1'b1);
        chk("pair_valid", ms_valid, 1);
        chk("pair_beat", ms_data, beat(32'hA, 32'hB, 2'b11, 1'b1));
        cycle(acc);

        send(32'hC, 1'b1);
        chk("single_beat", ms_data, beat(32'hC, '0, 2'b01, 1'b1));
        send(32'hD, 1'b1);
        chk("single_again", ms_data, beat(32'hD, '0, 2'b01, 1'b1));
        cycle(acc);

        send(32'h1, 1'b0);
        send(32'h2, 1'b0);
        chk("pkt3_beat0", ms_data, beat(32'h1, 32'h2, 2'b11, 1'b0));
        send(32'h3, 1'b1);
        chk("pkt3_beat1", ms_data, beat(32'h3, '0, 2'b01, 1'b1));
        send(32'h4, 1'b0);
        send(32'h5, 1'b1);
        chk("pkt2_beat", ms_data, beat(32'h4, 32'h5, 2'b11, 1'b1));
        cycle(acc);

        ms_ready = 1'b0;
        send(32'hA, 1'b0);
        send(32'hB, 1'b1);
        ss_data  = 32'hE;
        ss_last  = 1'b1;
        ss_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(acc);
            chk("stall_no_accept", acc, 0);
        end
        ms_ready = 1'b1;
        cycle(acc);
        chk("resume_accept", acc, 1);
        ss_valid = 1'b0;
        chk("resume_beat", ms_data, beat(32'hE, '0, 2'b01, 1'b1));
        cycle(acc);

        send(32'h7, 1'b0);
        for (int i = 0; i < 4; i++) cycle(acc);
        chk("half_idle_no_beat", ms_valid, 0);
        resetn = 1'b0;
        cycle(acc);
        cycle(acc);
        resetn = 1'b1;
        send(32'h8, 1'b1);
        chk("post_reset_beat", ms_data, beat(32'h8, '0, 2'b01, 1'b1));
        cycle(acc);

        for (int i = 0; i < 1500; i++) begin
            ss_valid = ($urandom_range(0, 3) != 0);
            ss_data  = $urandom;
            ss_last  = ($urandom_range(0, 3) == 0);
            ms_ready = ($urandom_range(0, 3) != 0);
            cycle(acc);
        end
        ss_valid = 1'b0;
        ms_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle(acc);
        chk("drain_empty", exp_q.size(), 0);

`ifdef STREAM_PACKER_STATS_EN
        resetn = 1'b0;
        cycle(acc);
        resetn = 1'b1;
        for (int i = 0; i < (1 << CNT_W) + 3; i++) send(i, 1'b1);
        cycle(acc);
        chk("stats_wrap", pkt_count, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_packer.md
STREAM_PACKER -- requirements
Module: stream_packer

Interface
REQ-001 SHALL have parameter IN_W, default 32: input word width; output data field is 2*IN_W.
REQ-002 SHALL have parameter OUT_W, default 72: output width, matching the downstream 72-bit BRAM FIFO; SHALL equal 2*IN_W+8.
REQ-003 SHALL have parameter CNT_W, default 16: packet counter width (STREAM_PACKER_STATS_EN only).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 resetn  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 ss_data  input  IN_W  upstream word.
REQ-007 ss_last  input  1  marks final word of a packet.
REQ-008 ss_valid  input  1  upstream word valid.
REQ-009 ss_ready  output  1  packer accepts word this cycle.
REQ-010 ms_data  output  OUT_W  packed beat to the FIFO.
REQ-011 ms_valid  output  1  ms_data valid.
REQ-012 ms_ready  input  1  FIFO accepts beat this cycle.
REQ-013 pkt_count  output  CNT_W  count of emitted beats with last=1 (STREAM_PACKER_STATS_EN only).

Function
REQ-014 Transfer occurs only on a cycle with valid && ready, on both ports; ms_data/ms_valid SHALL hold stable while ms_valid && !ms_ready.
REQ-015 Output beat format SHALL be: [IN_W-1:0] first (low) word; [2*IN_W-1:IN_W] second (high) word; [2*IN_W+1:2*IN_W] word mask; [2*IN_W+2] last; [OUT_W-1:2*IN_W+3] zero.
REQ-016 ss_ready SHALL equal (!ms_valid || ms_ready) in every state; no dependence on ss_valid or ss_last.
REQ-017 FSM SHALL have two states: EMPTY (no word held) and HALF (low word held in hold register).
REQ-018 EMPTY, accepted word with last=0: store word, go HALF; no output change.
REQ-019 EMPTY, accepted word with last=1: next cycle ms_valid=1, low=word, high=0, mask=2'b01, last=1; stay EMPTY.
REQ-020 HALF, accepted word: next cycle ms_valid=1, low=held word, high=word, mask=2'b11, last=ss_last; go EMPTY.
REQ-021 Latency: ms_valid SHALL rise exactly one cycle after the accepting edge of the completing word.
REQ-022 ms_valid SHALL drop after ms_ready handshake unless a new beat is loaded on the same edge (back-to-back allowed, no bubble).
REQ-023 A packet of odd length SHALL end with a mask=01 beat; even length ends with mask=11; packets never share a beat.
REQ-024 Hold register SHALL persist indefinitely in HALF while ss_valid is low.

Reset
REQ-025 While resetn=0: state=EMPTY, ms_valid=0, ms_data=0, hold register=0, pkt_count=0; ss_ready SHALL be 0 during reset.
REQ-026 Reset mid-packet SHALL discard held word and pending output beat; first word after reset is a packet start.

Configuration
REQ-027 With STREAM_PACKER_STATS_EN defined: pkt_count port and counter present; increments by 1 on each ms handshake with last=1; wraps from 2^CNT_W-1 to 0.
REQ-028 Without STREAM_PACKER_STATS_EN: port and counter absent; all other behaviour identical.

Structure
REQ-029 Shared package SHALL hold FSM state encoding (EMPTY, HALF), mask constants (MASK_LO=2'b01, MASK_BOTH=2'b11) and field-offset constants for the 72-bit beat format, shared with the FIFO's consumer.
REQ-030 Single module, no sub-module; output register is local (no separate skid instance).

Verification
REQ-031 Words 0xA,0xB(last), ms_ready=1 -> one beat: low=0xA, high=0xB, mask=11, last=1, one cycle after 0xB accepted.
REQ-032 Single word 0xC(last) -> beat low=0xC, high=0, mask=01, last=1; state EMPTY.
REQ-033 Packet 1,2,3(last) then 4,5(last), continuous valid -> beats {1,2,11,0},{3,0,01,1},{4,5,11,1}; no mixing.
REQ-034 ms_ready=0 for 5 cycles with beat pending -> ms_data stable, ss_ready=0 throughout; resumes with no loss or duplication.
REQ-035 resetn=0 while in HALF holding 0x7 -> after release, word 0x8(last) yields low=0x8, mask=01; 0x7 never emitted.
REQ-036 STATS build: 2^CNT_W+3 single-word packets -> pkt_count=3.
